// File: rtl/regfile_arbiter.sv
// regfile_arbiter: two-requester register file with lockable grant; define REGFILE_ARB_ROUND_ROBIN_EN for round-robin tie-break.
module regfile_arbiter #(
    parameter int DATA_W = 16,
    parameter int DEPTH = 8,
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_wr,
    input  logic [AW-1:0]     req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    input  logic              req0_lock,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_wr,
    input  logic [AW-1:0]     req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    input  logic              req1_lock,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata
);
    localparam logic [1:0] ARB = 2'd0, LOCK0 = 2'd1, LOCK1 = 2'd2;
    logic [1:0] st;
    logic [DATA_W-1:0] regs [2**AW];
    logic tie0, sel, xfer, wr, lock, rv0, rv1;
    logic [AW-1:0] addr;
    logic [DATA_W-1:0] wdata, rdata;
`ifdef REGFILE_ARB_ROUND_ROBIN_EN
    logic ptr;
    assign tie0 = !ptr;
    always_ff @(posedge clk)
        ptr <= reset ? 1'b0 : req0_ready ? 1'b1 : req1_ready ? 1'b0 : ptr;
`else
    assign tie0 = 1'b1;
`endif
    assign req0_ready = !reset && req0_valid && (st == LOCK0 || (st == ARB && (!req1_valid || tie0)));
    assign req1_ready = !reset && req1_valid && (st == LOCK1 || (st == ARB && (!req0_valid || !tie0)));
    assign sel = req1_ready;
    assign xfer = req0_ready || req1_ready;
    assign wr = sel ? req1_wr : req0_wr;
    assign lock = sel ? req1_lock : req0_lock;
    assign addr = sel ? req1_addr : req0_addr;
    assign wdata = sel ? req1_wdata : req0_wdata;
    // entries at or above DEPTH are never written, so they always read back as zero
    assign rdata = regs[addr];
    assign rsp0_valid = rv0 && !reset;
    assign rsp1_valid = rv1 && !reset;
    always_ff @(posedge clk)
        for (int i = 0; i < 2**AW; i++)
            if (reset) regs[i] <= '0;
            else if (xfer && wr && addr == AW'(i) && i < DEPTH) regs[i] <= wdata;
    always_ff @(posedge clk) begin
        if (reset) begin
            st <= ARB;
            rv0 <= 1'b0;
            rv1 <= 1'b0;
            rsp0_rdata <= '0;
            rsp1_rdata <= '0;
        end else begin
            st <= xfer ? (lock ? (sel ? LOCK1 : LOCK0) : ARB) : st;
            rv0 <= req0_ready && !req0_wr;
            rv1 <= req1_ready && !req1_wr;
            rsp0_rdata <= (req0_ready && !req0_wr) ? rdata : rsp0_rdata;
            rsp1_rdata <= (req1_ready && !req1_wr) ? rdata : rsp1_rdata;
        end
    end
endmodule
